i2c_slave: RTL and testbench

- 7-bit-address I2C target. It is oversampled in the system clock domain and drives SDA open-drain.
- Master writes: received bytes appear on data_out.
- Master reads: the byte on data_in is shifted out.
- Sits between a board-level I2C bus and a simple register or data source/sink in the fabric.

---
 rtl/i2c_slave.sv | 190 +++++++++++++++++++
 tb/tb_i2c_slave.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// 7-bit-address I2C target, oversampled in the clk domain, open-drain SDA.
// Optional general-call (address 0, write) support via I2C_SLAVE_GENERAL_CALL_EN.
module i2c_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] data_out,
    input  logic [7:0] data_in,
    input  logic [6:0] slave_addr
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StWaitStop
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, sda_prev_q;
    logic [7:0]             shift_q, shift_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   rw_q, rw_d;
    logic                   ack_q, ack_d;
    logic                   sda_oe_q, sda_oe_d;
    logic [7:0]             data_out_q, data_out_d;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;
    logic       addr_hit;

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign data_out = data_out_q;

    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign rx_byte = {shift_q[6:0], sda_s};

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    // General call is write-only; address 0 with R/W=1 falls through to a NACK.
    assign addr_hit = (rx_byte[7:1] == slave_addr) || (rx_byte == 8'h00);
`else
    assign addr_hit = (rx_byte[7:1] == slave_addr);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Sync chain resets to the idle-high bus level so release cannot fake an edge.
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= StIdle;
            shift_q    <= 8'h00;
            cnt_q      <= 4'd0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            sda_oe_q   <= 1'b0;
            data_out_q <= 8'h00;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            sda_oe_q   <= sda_oe_d;
            data_out_q <= data_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        sda_oe_d   = sda_oe_q;
        data_out_d = data_out_q;

        case (state_q)
            StAddr: begin
                if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = 4'd0;
                        rw_d    = sda_s;
                        ack_d   = 1'b0;
                        state_d = addr_hit ? StAddrAck : StWaitStop;
                    end
                end
            end
            StAddrAck, StWrAck: begin
                // First falling edge starts the ACK, the second ends it.
                if (scl_fall) begin
                    if (!ack_q) begin
                        ack_d    = 1'b1;
                        sda_oe_d = 1'b1;
                        if (rw_q) shift_d = data_in;
                    end else begin
                        ack_d = 1'b0;
                        if (rw_q) begin
                            state_d  = StRdData;
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                            cnt_d    = 4'd1;
                        end else begin
                            state_d  = StWrData;
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                        end
                    end
                end
            end
            StWrData: begin
                if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        data_out_d = rx_byte;
                        cnt_d      = 4'd0;
                        ack_d      = 1'b0;
                        state_d    = StWrAck;
                    end
                end
            end
            StRdData: begin
                if (scl_fall) begin
                    if (cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = StRdAck;
                    end else begin
                        sda_oe_d = ~shift_q[7];
                        shift_d  = {shift_q[6:0], 1'b0};
                        cnt_d    = cnt_q + 4'd1;
                    end
                end
            end
            StRdAck: begin
                if (scl_rise) begin
                    if (!sda_s) begin
                        shift_d = data_in;
                        cnt_d   = 4'd0;
                        state_d = StRdData;
                    end else begin
                        state_d = StWaitStop;
                    end
                end
            end
            default: ;
        endcase

        if (start_det) begin
            state_d  = StAddr;
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            ack_d    = 1'b0;
        end else if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            ack_d    = 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: a bit-banged I2C master plus a transaction-level
// model of what the target should ACK, return and latch.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int SYNC = 2;
    localparam int Q    = 100;
    localparam int H    = 200;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic [7:0] data_out;
    logic [7:0] data_in = 8'h00;
    logic [6:0] slave_addr = 7'h55;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_dout = 8'h00;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .data_out  (data_out),
        .data_in   (data_in),
        .slave_addr(slave_addr)
    );

    // Model: which address bytes the target should acknowledge.
    function automatic logic model_ack(input logic [7:0] a, input logic [6:0] own);
        return (a[7:1] == own) || (GC && a == 8'h00);
    endfunction

    task automatic write_bit(input logic b);
        m_low = ~b;
        #Q scl = 1'b1;
        #H scl = 1'b0;
        #Q;
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0;
        #Q scl = 1'b1;
        #(H/2) b = sda;
        #(H/2) scl = 1'b0;
        #Q;
    endtask

    task automatic do_start();
        m_low = 1'b0;
        #Q scl = 1'b1;
        #Q m_low = 1'b1;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic do_stop();
        m_low = 1'b1;
        #Q scl = 1'b1;
        #Q m_low = 1'b0;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic nack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(nack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic mnack, input logic [7:0] next_din);
        for (int i = 7; i >= 0; i--) read_bit(b[i]);
        data_in = next_din;
        write_bit(mnack);
    endtask

    task automatic test_reset();
        tests_run++;
        if (data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_data_out: got %h want 00", data_out);
        end
        tests_run++;
        if (sda !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_sda: got %b want 1", sda);
        end
    endtask

    task automatic test_write_match();
        logic       nack;
        logic [7:0] b;
        slave_addr = 7'h55;
        do_start();
        write_byte(8'hAA, nack);
        tests_run++;
        if (nack !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_addr_ack: got %b want 0", nack);
        end
        b = 8'hCC;
        for (int i = 7; i >= 1; i--) write_bit(b[i]);
        // Eighth data bit: check the exact SYNC_STAGES+1 clk update latency of data_out.
        m_low = ~b[0];
        #Q @(negedge clk) scl = 1'b1;
        repeat (SYNC) @(posedge clk);
        #1;
        tests_run++;
        if (data_out !== exp_dout) begin
            tests_failed++;
            $display("FAIL wr_early: got %h want %h", data_out, exp_dout);
        end
        @(posedge clk);
        #1;
        exp_dout = 8'hCC;
        tests_run++;
        if (data_out !== exp_dout) begin
            tests_failed++;
            $display("FAIL wr_latency: got %h want %h", data_out, exp_dout);
        end
        #H scl = 1'b0;
        #Q;
        read_bit(nack);
        tests_run++;
        if (nack !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_data_ack: got %b want 0", nack);
        end
        do_stop();
        tests_run++;
        if (data_out !== exp_dout) begin
            tests_failed++;
            $display("FAIL wr_hold_stop: got %h want %h", data_out, exp_dout);
        end
    endtask

    task automatic test_mismatch();
        logic nack;
        slave_addr = 7'h55;
        do_start();
        write_byte(8'h54, nack);
        tests_run++;
        if (nack !== 1'b1) begin
            tests_failed++;
            $display("FAIL mis_addr_nack: got %b want 1", nack);
        end
        write_byte(8'h11, nack);
        tests_run++;
        if (nack !== 1'b1 || data_out !== exp_dout) begin
            tests_failed++;
            $display("FAIL mis_data: nack %b data_out %h want 1 %h", nack, data_out, exp_dout);
        end
        do_stop();
    endtask

    task automatic test_read();
        logic       nack;
        logic [7:0] b;
        slave_addr = 7'h55;
        data_in = 8'hA5;
        do_start();
        write_byte(8'hAB, nack);
        tests_run++;
        if (nack !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_addr_ack: got %b want 0", nack);
        end
        read_byte(b, 1'b0, 8'h3C);
        tests_run++;
        if (b !== 8'hA5) begin
            tests_failed++;
            $display("FAIL rd_byte0: got %h want a5", b);
        end
        read_byte(b, 1'b1, 8'h00);
        tests_run++;
        if (b !== 8'h3C) begin
            tests_failed++;
            $display("FAIL rd_byte1: got %h want 3c", b);
        end
        #Q;
        tests_run++;
        if (sda !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_release: got %b want 1", sda);
        end
        do_stop();
    endtask

    task automatic test_back_to_back();
        logic       nack;
        logic [7:0] seq [3];
        seq[0] = 8'h12;
        seq[1] = 8'h34;
        seq[2] = 8'h56;
        slave_addr = 7'h55;
        do_start();
        write_byte(8'hAA, nack);
        tests_run++;
        if (nack !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_addr_ack: got %b want 0", nack);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                do_start();
                write_byte(8'hAA, nack);
                tests_run++;
                if (nack !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_readdr_ack: got %b want 0", nack);
                end
            end
            write_byte(seq[i], nack);
            exp_dout = seq[i];
            tests_run++;
            if (nack !== 1'b0 || data_out !== exp_dout) begin
                tests_failed++;
                $display("FAIL b2b_byte%0d: nack %b data_out %h want 0 %h",
                         i, nack, data_out, exp_dout);
            end
        end
        do_stop();
    endtask

    task automatic test_reset_mid();
        logic       nack;
        logic [7:0] a;
        logic [7:0] d;
        slave_addr = 7'h55;
        a = 8'hAA;
        do_start();
        for (int i = 7; i >= 0; i--) write_bit(a[i]);
        m_low = 1'b0;
        #Q scl = 1'b1;
        #(H/2);
        tests_run++;
        if (sda !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_ack_low: got %b want 0", sda);
        end
        rst = 1'b0;
        #1;
        exp_dout = 8'h00;
        tests_run++;
        if (sda !== 1'b1 || data_out !== exp_dout) begin
            tests_failed++;
            $display("FAIL rstmid_async: sda %b data_out %h want 1 00", sda, data_out);
        end
        #30 rst = 1'b1;
        #(H/2) scl = 1'b0;
        #Q;
        do_stop();
        d = 8'($urandom);
        do_start();
        write_byte(a, nack);
        write_byte(d, nack);
        exp_dout = d;
        tests_run++;
        if (nack !== 1'b0 || data_out !== exp_dout) begin
            tests_failed++;
            $display("FAIL rstmid_recover: nack %b data_out %h want 0 %h", nack, data_out, d);
        end
        do_stop();
    endtask

    task automatic test_general_call();
        logic nack;
        slave_addr = 7'h3C;
        do_start();
        write_byte(8'h00, nack);
        tests_run++;
        if (nack !== !GC) begin
            tests_failed++;
            $display("FAIL gc_addr: got %b want %b", nack, !GC);
        end
        write_byte(8'h77, nack);
        if (GC) exp_dout = 8'h77;
        tests_run++;
        if (nack !== !GC || data_out !== exp_dout) begin
            tests_failed++;
            $display("FAIL gc_data: nack %b data_out %h want %b %h", nack, data_out, !GC, exp_dout);
        end
        do_stop();
        do_start();
        write_byte(8'h01, nack);
        tests_run++;
        if (nack !== 1'b1) begin
            tests_failed++;
            $display("FAIL gc_read_nack: got %b want 1", nack);
        end
        do_stop();
    endtask

    task automatic test_random();
        logic       nack;
        logic       ack_exp;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] cur;
        logic [7:0] nxt;
        int         kind;
        int         n;
        for (int k = 0; k < 14; k++) begin
            slave_addr = 7'($urandom_range(1, 127));
            kind = int'($urandom_range(0, 2));
            if (kind == 1) a = {7'($urandom), 1'b0};
            else a = {slave_addr, kind == 2};
            ack_exp = model_ack(a, slave_addr);
            n = int'($urandom_range(1, 3));
            cur = 8'($urandom);
            data_in = cur;
            do_start();
            write_byte(a, nack);
            tests_run++;
            if (nack !== !ack_exp) begin
                tests_failed++;
                $display("FAIL rand%0d_addr %h: got %b want %b", k, a, nack, !ack_exp);
            end
            if (ack_exp && a[0]) begin
                for (int j = 0; j < n; j++) begin
                    nxt = 8'($urandom);
                    read_byte(b, j == n - 1, nxt);
                    tests_run++;
                    if (b !== cur) begin
                        tests_failed++;
                        $display("FAIL rand%0d_rd%0d: got %h want %h", k, j, b, cur);
                    end
                    cur = nxt;
                end
            end else begin
                for (int j = 0; j < n; j++) begin
                    b = 8'($urandom);
                    write_byte(b, nack);
                    if (ack_exp) exp_dout = b;
                    tests_run++;
                    if (nack !== !ack_exp || data_out !== exp_dout) begin
                        tests_failed++;
                        $display("FAIL rand%0d_wr%0d: nack %b data_out %h want %b %h",
                                 k, j, nack, data_out, !ack_exp, exp_dout);
                    end
                end
            end
            do_stop();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #33 rst = 1'b1;
        #100;
        test_reset();
        test_write_match();
        test_mismatch();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_general_call();
        test_random();
        #200;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
